// File: rtl/rpn_exec_ctrl_pkg.sv
// Shared codes for the RPN command sequencer: command kinds, response status,
// ALU operation codes, FSM states and the operand-arity decode.
package rpn_exec_ctrl_pkg;

    localparam logic [1:0] CMD_PUSH  = 2'd0;
    localparam logic [1:0] CMD_OP    = 2'd1;
    localparam logic [1:0] CMD_DROP  = 2'd2;
    localparam logic [1:0] CMD_CLEAR = 2'd3;

    localparam logic [2:0] ST_OK        = 3'd0;
    localparam logic [2:0] ST_UNDERFLOW = 3'd1;
    localparam logic [2:0] ST_OVERFLOW  = 3'd2;
    localparam logic [2:0] ST_ARITH     = 3'd3;
    localparam logic [2:0] ST_SHIFT     = 3'd4;

    localparam logic [3:0] ALU_PUR = 4'd0;   // pass operand a through
    localparam logic [3:0] ALU_UAD = 4'd1;
    localparam logic [3:0] ALU_SAD = 4'd2;
    localparam logic [3:0] ALU_USB = 4'd3;
    localparam logic [3:0] ALU_SSB = 4'd4;
    localparam logic [3:0] ALU_AND = 4'd5;
    localparam logic [3:0] ALU_OR  = 4'd6;
    localparam logic [3:0] ALU_XOR = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8;
    localparam logic [3:0] ALU_ULT = 4'd9;
    localparam logic [3:0] ALU_SHL = 4'd10;
    localparam logic [3:0] ALU_SHR = 4'd11;
    localparam logic [3:0] ALU_UNC = 4'd12;  // constant source, no operands

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Codes above ALU_UNC map to ALU_PUR.
    function automatic logic [3:0] alu_op_canon(input logic [3:0] op);
        return (op > ALU_UNC) ? ALU_PUR : op;
    endfunction

    function automatic logic [1:0] alu_arity(input logic [3:0] op);
        logic [1:0] n;
        case (alu_op_canon(op))
            ALU_UNC:                            n = 2'd0;
            ALU_PUR, ALU_SHL, ALU_SHR:          n = 2'd1;
            default:                            n = 2'd2;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rpn_exec_ctrl_stack.sv
// DEPTH x W register stack with a combined pop of 0..2 and push of 0..1 per edge.
// Reset clears only the entry count; stored words keep stale values.
module rpn_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [1:0]               pop_n,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             tos,
    output logic [W-1:0]             nos,
    output logic [$clog2(DEPTH):0]   depth
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [DW-1:0] base;
    logic [DW-1:0] tos_idx;
    logic [DW-1:0] nos_idx;

    // The pops happen first, so a push lands in the slot just above what survives.
    assign base    = depth - DW'(pop_n);
    assign tos_idx = depth - DW'(1);
    assign nos_idx = depth - DW'(2);

    assign tos = (depth > DW'(0)) ? mem[tos_idx[AW-1:0]] : '0;
    assign nos = (depth > DW'(1)) ? mem[nos_idx[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            depth <= '0;
        end else begin
            depth <= base + DW'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[base[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/rpn_exec_ctrl.sv
// RPN command sequencer: owns the operand stack, checks each command, drives the
// external ALU for one cycle on valid operations and reports a status pulse.
module rpn_exec_ctrl
    import rpn_exec_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_kind,
    input  logic [W-1:0]             cmd_data,
    input  logic [3:0]               cmd_alu_op,
    output logic [W-1:0]             alu_operand_a,
    output logic [W-1:0]             alu_operand_b,
    output logic [3:0]               alu_op,
    input  logic [W-1:0]             alu_result,
    input  logic                     alu_arith_ovf,
    input  logic                     alu_shift_ovf,
    output logic                     rsp_valid,
    output logic [2:0]               rsp_status,
    output logic [W-1:0]             top_data,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     err_sticky
);
    localparam int DW = $clog2(DEPTH) + 1;

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE outside reset, and the fields must hold until then.
    state_t         state;
    logic [1:0]     arity_q;

    logic           st_rst;
    logic           st_push;
    logic [1:0]     st_pop;
    logic [W-1:0]   st_wdata;
    logic [W-1:0]   st_tos;
    logic [W-1:0]   st_nos;
    logic [DW-1:0]  st_depth;

    logic           full;
    logic           empty;
    logic [1:0]     op_arity;
    logic [2:0]     acc_status;
    logic           acc_exec;
    logic [2:0]     exec_status;

    assign cmd_ready = (state == S_IDLE) && !rst;
    assign full      = (st_depth == DW'(DEPTH));
    assign empty     = (st_depth == '0);
    assign op_arity  = alu_arity(cmd_alu_op);
    assign top_data  = st_tos;
    assign depth     = st_depth;

    assign exec_status = alu_arith_ovf ? ST_ARITH :
                         alu_shift_ovf ? ST_SHIFT : ST_OK;

    // Checks applied to the command being offered; only used on the accept edge.
    always_comb begin
        acc_status = ST_OK;
        acc_exec   = 1'b0;
        case (cmd_kind)
            CMD_PUSH: if (full)  acc_status = ST_OVERFLOW;
            CMD_DROP: if (empty) acc_status = ST_UNDERFLOW;
            CMD_OP: begin
                if (st_depth < DW'(op_arity))           acc_status = ST_UNDERFLOW;
                else if (op_arity == 2'd0 && full)      acc_status = ST_OVERFLOW;
                else                                    acc_exec   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        st_push  = 1'b0;
        st_pop   = 2'd0;
        st_wdata = cmd_data;
        st_rst   = rst;
        if (state == S_IDLE && cmd_valid) begin
            case (cmd_kind)
                CMD_PUSH:  st_push = !full;
                CMD_DROP:  st_pop  = {1'b0, !empty};
                CMD_CLEAR: st_rst  = 1'b1;
                default: ;
            endcase
        end else if (state == S_EXEC) begin
            st_push  = 1'b1;
            st_pop   = arity_q;
            st_wdata = alu_result;
        end
    end

    rpn_stack #(.DEPTH(DEPTH), .W(W)) u_stack (
        .clk   (clk),
        .rst   (st_rst),
        .push  (st_push),
        .pop_n (st_pop),
        .wdata (st_wdata),
        .tos   (st_tos),
        .nos   (st_nos),
        .depth (st_depth)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            arity_q       <= 2'd0;
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            alu_op        <= ALU_PUR;
            rsp_valid     <= 1'b0;
            rsp_status    <= ST_OK;
            err_sticky    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (acc_exec) begin
                            state         <= S_EXEC;
                            arity_q       <= op_arity;
                            alu_op        <= alu_op_canon(cmd_alu_op);
                            alu_operand_a <= (op_arity == 2'd2) ? st_nos :
                                             (op_arity == 2'd1) ? st_tos : '0;
                            alu_operand_b <= (op_arity == 2'd2) ? st_tos : '0;
                        end else begin
                            state      <= S_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= acc_status;
                            if (cmd_kind == CMD_CLEAR)    err_sticky <= 1'b0;
                            else if (acc_status != ST_OK) err_sticky <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    state         <= S_RESP;
                    rsp_valid     <= 1'b1;
                    rsp_status    <= exec_status;
                    alu_op        <= ALU_PUR;
                    alu_operand_a <= '0;
                    alu_operand_b <= '0;
                    if (exec_status != ST_OK) err_sticky <= 1'b1;
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_exec_ctrl.sv
// Bench for rpn_exec_ctrl: behavioural ALU, queue-based stack reference model,
// directed scenarios followed by random command streams.
module tb_rpn_exec_ctrl;
    import rpn_exec_ctrl_pkg::*;

    localparam int DEPTH = 8;
    localparam int W     = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_kind = CMD_PUSH;
    logic [W-1:0] cmd_data = '0;
    logic [3:0]   cmd_alu_op = ALU_PUR;
    logic [W-1:0] alu_operand_a;
    logic [W-1:0] alu_operand_b;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_result;
    logic         alu_arith_ovf;
    logic         alu_shift_ovf;
    logic         rsp_valid;
    logic [2:0]   rsp_status;
    logic [W-1:0] top_data;
    logic [3:0]   depth;
    logic         err_sticky;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0]   stk[$];
    logic         m_err;
    logic [2:0]   exp_q[$];

    always #5 clk = ~clk;

    rpn_exec_ctrl #(.DEPTH(DEPTH), .W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_kind      (cmd_kind),
        .cmd_data      (cmd_data),
        .cmd_alu_op    (cmd_alu_op),
        .alu_operand_a (alu_operand_a),
        .alu_operand_b (alu_operand_b),
        .alu_op        (alu_op),
        .alu_result    (alu_result),
        .alu_arith_ovf (alu_arith_ovf),
        .alu_shift_ovf (alu_shift_ovf),
        .rsp_valid     (rsp_valid),
        .rsp_status    (rsp_status),
        .top_data      (top_data),
        .depth         (depth),
        .err_sticky    (err_sticky)
    );

    // Behavioural ALU: returns {arith_ovf, shift_ovf, result}.
    function automatic logic [9:0] alu_eval(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, s;
        logic [8:0] u;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            ALU_UAD: begin u = {1'b0, a} + {1'b0, b}; return {u[8], 1'b0, u[7:0]}; end
            ALU_SAD: begin s = sa + sb; return {(s > 127 || s < -128), 1'b0, 8'(s)}; end
            ALU_USB: return {(a < b), 1'b0, 8'(a - b)};
            ALU_SSB: begin s = sa - sb; return {(s > 127 || s < -128), 1'b0, 8'(s)}; end
            ALU_AND: return {2'b00, a & b};
            ALU_OR:  return {2'b00, a | b};
            ALU_XOR: return {2'b00, a ^ b};
            ALU_SLT: return {2'b00, 7'd0, (sa < sb)};
            ALU_ULT: return {2'b00, 7'd0, (a < b)};
            ALU_SHL: return {1'b0, a[7], a << 1};
            ALU_SHR: return {1'b0, a[0], a >> 1};
            ALU_UNC: return {2'b00, 8'hA5};
            default: return {2'b00, a};
        endcase
    endfunction

    always_comb begin
        logic [9:0] r;
        r = alu_eval(alu_op, alu_operand_a, alu_operand_b);
        alu_result    = r[7:0];
        alu_shift_ovf = r[8];
        alu_arith_ovf = r[9];
    end

    function automatic int ref_arity(input logic [3:0] op);
        if (op == ALU_UNC) return 0;
        if (op == ALU_PUR || op == ALU_SHL || op == ALU_SHR || op > ALU_UNC) return 1;
        return 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_top();
        return (stk.size() > 0) ? stk[$] : 8'h00;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the response.
    task automatic run_cmd(input logic [1:0] kind, input logic [7:0] data, input logic [3:0] op);
        logic [2:0] est;
        logic       exec;
        logic [7:0] ea, eb;
        logic [3:0] eop;
        logic [9:0] r;
        int         ar;
        est = ST_OK; exec = 1'b0; ea = 8'h00; eb = 8'h00; eop = ALU_PUR;
        case (kind)
            CMD_PUSH:  if (stk.size() == DEPTH) est = ST_OVERFLOW; else stk.push_back(data);
            CMD_DROP:  if (stk.size() == 0) est = ST_UNDERFLOW; else void'(stk.pop_back());
            CMD_CLEAR: stk.delete();
            default: begin
                ar = ref_arity(op);
                if (stk.size() < ar) est = ST_UNDERFLOW;
                else if (ar == 0 && stk.size() == DEPTH) est = ST_OVERFLOW;
                else begin
                    exec = 1'b1;
                    eop  = (op > ALU_UNC) ? ALU_PUR : op;
                    if (ar == 2) begin eb = stk.pop_back(); ea = stk.pop_back(); end
                    else if (ar == 1) ea = stk.pop_back();
                    r = alu_eval(eop, ea, eb);
                    stk.push_back(r[7:0]);
                    est = r[9] ? ST_ARITH : (r[8] ? ST_SHIFT : ST_OK);
                end
            end
        endcase
        if (kind == CMD_CLEAR) m_err = 1'b0;
        else if (est != ST_OK) m_err = 1'b1;
        exp_q.push_back(est);

        check("ready_before", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_kind = kind; cmd_data = data; cmd_alu_op = op;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (exec) begin
            check("exec_no_rsp", rsp_valid, 0);
            check("exec_ready", cmd_ready, 0);
            check("exec_alu_op", alu_op, eop);
            check("exec_a", alu_operand_a, ea);
            check("exec_b", alu_operand_b, eb);
            @(negedge clk);
        end
        check("resp_alu_op", alu_op, ALU_PUR);
        check("resp_valid", rsp_valid, 1);
        check("resp_status", rsp_status, exp_q.pop_front());
        check("resp_top", top_data, exp_top());
        check("resp_depth", depth, stk.size());
        check("resp_err", err_sticky, m_err);
        @(negedge clk);
        check("pulse_end", rsp_valid, 0);
    endtask

    initial begin
        int k;
        m_err = 1'b0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", cmd_ready, 0);
        check("rst_depth", depth, 0);
        check("rst_top", top_data, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_status", rsp_status, ST_OK);
        check("rst_err", err_sticky, 0);
        check("rst_alu_op", alu_op, ALU_PUR);
        check("rst_a", alu_operand_a, 0);
        check("rst_b", alu_operand_b, 0);
        rst = 1'b0;
        @(negedge clk);

        run_cmd(CMD_PUSH, 8'd3, ALU_PUR);
        run_cmd(CMD_PUSH, 8'd4, ALU_PUR);
        run_cmd(CMD_OP, 8'd0, ALU_UAD);
        check("add_top7", top_data, 7);
        check("add_depth1", depth, 1);

        run_cmd(CMD_CLEAR, 8'd0, ALU_PUR);
        run_cmd(CMD_PUSH, 8'd200, ALU_PUR);
        run_cmd(CMD_PUSH, 8'd100, ALU_PUR);
        run_cmd(CMD_OP, 8'd0, ALU_UAD);
        check("ovf_top44", top_data, 44);
        check("ovf_status", rsp_status, ST_ARITH);
        check("ovf_err", err_sticky, 1);
        run_cmd(CMD_CLEAR, 8'd0, ALU_PUR);
        check("clr_depth", depth, 0);
        check("clr_err", err_sticky, 0);

        run_cmd(CMD_PUSH, 8'd5, ALU_PUR);
        run_cmd(CMD_OP, 8'd0, ALU_UAD);
        check("und_depth1", depth, 1);
        check("und_top5", top_data, 5);

        run_cmd(CMD_CLEAR, 8'd0, ALU_PUR);
        for (int i = 0; i < 8; i++) run_cmd(CMD_PUSH, 8'(i + 1), ALU_PUR);
        run_cmd(CMD_PUSH, 8'd9, ALU_PUR);
        check("full_depth8", depth, 8);
        check("full_top8", top_data, 8);
        run_cmd(CMD_OP, 8'd0, ALU_UNC);
        check("unc_full_status", rsp_status, ST_OVERFLOW);

        run_cmd(CMD_CLEAR, 8'd0, ALU_PUR);
        run_cmd(CMD_DROP, 8'd0, ALU_PUR);
        run_cmd(CMD_PUSH, 8'hFF, ALU_PUR);
        run_cmd(CMD_PUSH, 8'h01, ALU_PUR);
        run_cmd(CMD_OP, 8'd0, ALU_SLT);
        check("slt_top1", top_data, 1);
        run_cmd(CMD_PUSH, 8'h03, ALU_PUR);
        run_cmd(CMD_OP, 8'd0, ALU_SHR);
        check("shr_top1", top_data, 1);
        check("shr_status", rsp_status, ST_SHIFT);

        // Reset landing in the EXEC cycle discards the operation.
        run_cmd(CMD_PUSH, 8'd1, ALU_PUR);
        cmd_valid = 1'b1; cmd_kind = CMD_OP; cmd_alu_op = ALU_UAD; cmd_data = 8'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rx_exec_op", alu_op, ALU_UAD);
        rst = 1'b1;
        @(negedge clk);
        check("rx_no_rsp", rsp_valid, 0);
        check("rx_depth0", depth, 0);
        check("rx_ready_low", cmd_ready, 0);
        rst = 1'b0;
        stk.delete();
        m_err = 1'b0;
        @(negedge clk);
        check("rx_ready_back", cmd_ready, 1);
        check("rx_still_no_rsp", rsp_valid, 0);
        check("rx_depth_after", depth, 0);

        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 19);
            if (k < 9)       run_cmd(CMD_PUSH, 8'($urandom_range(0, 255)), ALU_PUR);
            else if (k < 16) run_cmd(CMD_OP, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
            else if (k < 19) run_cmd(CMD_DROP, 8'($urandom_range(0, 255)), ALU_PUR);
            else             run_cmd(CMD_CLEAR, 8'($urandom_range(0, 255)), ALU_PUR);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
